spi_xfer_queue: RTL

- Word-level transfer sequencer that sits directly upstream of the SPI shift register.
- Buffers host TX words in a FIFO and loads each word into the shift register via its latch/byte_sel/p_in interface.
- Starts each character with go, waits for tip to complete, then captures the parallel output into an RX FIFO.
- Lets the host queue back-to-back characters without polling per character.

---
 rtl/spi_xfer_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spi_xfer_queue.sv
// Word-level sequencer feeding an SPI shift register: TX FIFO -> latch/go/tip handshake -> RX FIFO.
// Each character is loaded whole (all byte lanes) and its parallel result is captured once tip falls.
module spi_xfer_queue #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          tx_wr,
  input  logic [DW-1:0] tx_data,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  input  logic          rx_rd,
  output logic [DW-1:0] rx_data,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          busy,
  output logic          xfer_done,
  output logic          tx_ovf,
  output logic          rx_udf,
  input  logic          err_clr,
  output logic          sh_latch,
  output logic [3:0]    sh_byte_sel,
  output logic [DW-1:0] sh_p_in,
  output logic          sh_go,
  input  logic          sh_tip,
  input  logic [DW-1:0] sh_p_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t state, state_nxt;

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full  = (tx_cnt == FULL_LVL);
  assign tx_level = tx_cnt;
  assign rx_empty = (rx_cnt == '0);
  assign rx_level = rx_cnt;
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp];

  assign tx_push = tx_wr && !tx_full;
  assign tx_pop  = (state == S_LOAD);
  assign rx_push = (state == S_CAPTURE);
  assign rx_pop  = rx_rd && !rx_empty;

  // Storage arrays carry data only; occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
    if (rx_push) rx_mem[rx_wp] <= sh_p_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + ONE;
        2'b01:   tx_cnt <= tx_cnt - ONE;
        default: tx_cnt <= tx_cnt;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + ONE;
        2'b01:   rx_cnt <= rx_cnt - ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Clear wins over a same-cycle error event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (err_clr)              tx_ovf <= 1'b0;
      else if (tx_wr && tx_full) tx_ovf <= 1'b1;
      if (err_clr)               rx_udf <= 1'b0;
      else if (rx_rd && rx_empty) rx_udf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // go stays low during LOAD because the shift register ignores latch while go is high.
  always_comb begin
    state_nxt   = state;
    sh_latch    = 1'b0;
    sh_byte_sel = 4'h0;
    sh_p_in     = '0;
    sh_go       = 1'b0;
    xfer_done   = 1'b0;
    busy        = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (enable && (tx_cnt != '0) && (rx_cnt != FULL_LVL)) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        sh_latch    = 1'b1;
        sh_byte_sel = 4'hF;
        sh_p_in     = tx_mem[tx_rp];
        state_nxt   = S_GO;
      end
      S_GO: begin
        sh_go = 1'b1;
        if (sh_tip) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!sh_tip) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        xfer_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
